adder_fu_sched: RTL and testbench

Round-robin scheduler that shares one segmented adder functional unit (4x16b / 2x32b / 1x64b modes) among NUM_REQ requesters inside a CGRA tile. It accepts one 64-bit add request at a time, maps operands onto the FU's eight 16-bit input lanes, drives the FU mode and enable, waits the FU latency, and returns the packed result to the issuing requester over a valid/ready handshake.

---
 rtl/adder_fu_pkg.sv | 42 ++++
 rtl/rr_arbiter.sv | 27 ++
 rtl/adder_fu_sched.sv | 176 +++++++++++++++++
 tb/tb_adder_fu_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_fu_pkg.sv
// Shared types and lane helpers for the segmented-adder scheduler.
package adder_fu_pkg;

  localparam int unsigned LANE_W = 16;
  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = LANE_W * LANES;

  typedef enum logic [1:0] {
    MODE_4X16    = 2'd0,
    MODE_2X32    = 2'd1,
    MODE_ILLEGAL = 2'd2,
    MODE_1X64    = 2'd3
  } fu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

  typedef logic [2*LANES-1:0][LANE_W-1:0] fu_in_t;
  typedef logic [LANES-1:0][LANE_W-1:0]   fu_out_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              carry;
    logic              err;
  } fu_resp_t;

  // Interleave operand segments onto FU lanes: even lanes carry a, odd lanes carry b.
  function automatic fu_in_t map_lanes(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
    fu_in_t lanes;
    lanes = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lanes[2*k]   = a[LANE_W*k +: LANE_W];
      lanes[2*k+1] = b[LANE_W*k +: LANE_W];
    end
    return lanes;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_fu_sched.sv
// Round-robin scheduler sharing one segmented adder FU among NUM_REQ requesters.
// Optional perf counters are enabled with ADDER_FU_SCHED_PERF_EN.
module adder_fu_sched
  import adder_fu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FU_LAT  = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][1:0]          req_mode,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]               resp_valid,
  input  logic [NUM_REQ-1:0]               resp_ready,
  output logic [DATA_W-1:0]                resp_data,
  output logic                             resp_carry,
  output logic                             resp_err,
  output logic                             fu_on_off,
  output logic [1:0]                       fu_config,
  output logic [2*LANES-1:0][LANE_W-1:0]   fu_inputs,
`ifdef ADDER_FU_SCHED_PERF_EN
  output logic [NUM_REQ-1:0][15:0]         perf_grants,
  output logic [15:0]                      perf_stall,
`endif
  input  logic [LANES-1:0][LANE_W-1:0]     fu_outputs,
  input  logic                             fu_carry
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  sched_state_e          state, state_d;
  logic [PTR_W-1:0]      rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]      owner, owner_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  fu_resp_t              resp_q, resp_d;
  logic [NUM_REQ-1:0]    resp_valid_d;
  logic                  fu_on_off_d;
  logic [1:0]            fu_config_d;
  fu_in_t                fu_inputs_d;

  logic [NUM_REQ-1:0]    grant;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      ptr_next;
  logic                  accept;
  fu_mode_e              gnt_mode;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // One-hot grant to index.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign accept    = (state == ST_IDLE) && (|grant);
  assign req_ready = (state == ST_IDLE) ? grant : '0;
  assign ptr_next  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  assign gnt_mode  = fu_mode_e'(req_mode[gnt_idx]);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    rr_ptr_d     = rr_ptr;
    owner_d      = owner;
    cnt_d        = cnt;
    resp_d       = resp_q;
    resp_valid_d = resp_valid;
    fu_on_off_d  = fu_on_off;
    fu_config_d  = fu_config;
    fu_inputs_d  = fu_inputs;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          owner_d  = gnt_idx;
          rr_ptr_d = ptr_next;
          if (gnt_mode == MODE_ILLEGAL) begin
            state_d      = ST_RESP;
            resp_d       = '{data: '0, carry: 1'b0, err: 1'b1};
            resp_valid_d = NUM_REQ'(1) << gnt_idx;
          end else begin
            state_d     = ST_EXEC;
            cnt_d       = '0;
            fu_on_off_d = 1'b1;
            fu_config_d = req_mode[gnt_idx];
            fu_inputs_d = map_lanes(req_a[gnt_idx], req_b[gnt_idx]);
          end
        end
      end

      ST_EXEC: begin
        if (cnt == CNT_W'(FU_LAT - 1)) begin
          state_d      = ST_RESP;
          cnt_d        = '0;
          resp_d       = '{data: fu_outputs, carry: fu_carry, err: 1'b0};
          resp_valid_d = NUM_REQ'(1) << owner;
          fu_on_off_d  = 1'b0;
          fu_config_d  = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      ST_RESP: begin
        // Return to IDLE only; arbitration resumes the following cycle.
        if (resp_ready[owner]) begin
          state_d      = ST_IDLE;
          resp_valid_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      cnt        <= '0;
      resp_q     <= '0;
      resp_valid <= '0;
      fu_on_off  <= 1'b0;
      fu_config  <= '0;
      fu_inputs  <= '0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      owner      <= owner_d;
      cnt        <= cnt_d;
      resp_q     <= resp_d;
      resp_valid <= resp_valid_d;
      fu_on_off  <= fu_on_off_d;
      fu_config  <= fu_config_d;
      fu_inputs  <= fu_inputs_d;
    end
  end

  assign resp_data  = resp_q.data;
  assign resp_carry = resp_q.carry;
  assign resp_err   = resp_q.err;

`ifdef ADDER_FU_SCHED_PERF_EN
  // Saturating grant and stall counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_grants <= '0;
      perf_stall  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept && (gnt_idx == PTR_W'(i)) && (perf_grants[i] != 16'hFFFF)) begin
          perf_grants[i] <= perf_grants[i] + 16'd1;
        end
      end
      if ((|req_valid) && (state != ST_IDLE) && (perf_stall != 16'hFFFF)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adder_fu_sched.sv
// Directed self-checking bench for adder_fu_sched with a behavioural FU (FU_LAT=2).
module tb_adder_fu_sched;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned FU_LAT  = 2;

  logic                         clk = 1'b0;
  logic                         reset = 1'b0;
  logic [NUM_REQ-1:0]           req_valid = '0;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0][1:0]      req_mode = '0;
  logic [NUM_REQ-1:0][63:0]     req_a = '0;
  logic [NUM_REQ-1:0][63:0]     req_b = '0;
  logic [NUM_REQ-1:0]           resp_valid;
  logic [NUM_REQ-1:0]           resp_ready = '0;
  logic [63:0]                  resp_data;
  logic                         resp_carry;
  logic                         resp_err;
  logic                         fu_on_off;
  logic [1:0]                   fu_config;
  logic [7:0][15:0]             fu_inputs;
  logic [3:0][15:0]             fu_outputs;
  logic                         fu_carry;
`ifdef ADDER_FU_SCHED_PERF_EN
  logic [NUM_REQ-1:0][15:0]     perf_grants;
  logic [15:0]                  perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_fu_sched #(.NUM_REQ(NUM_REQ), .FU_LAT(FU_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_carry (resp_carry),
    .resp_err   (resp_err),
    .fu_on_off  (fu_on_off),
    .fu_config  (fu_config),
    .fu_inputs  (fu_inputs),
`ifdef ADDER_FU_SCHED_PERF_EN
    .perf_grants(perf_grants),
    .perf_stall (perf_stall),
`endif
    .fu_outputs (fu_outputs),
    .fu_carry   (fu_carry)
  );

  // Behavioural segmented adder: result registered once per enabled cycle.
  function automatic logic [64:0] fu_model(input logic [7:0][15:0] in, input logic [1:0] m);
    logic [63:0] a, b;
    logic [64:0] r;
    logic [16:0] s16;
    logic [32:0] s32;
    for (int k = 0; k < 4; k++) begin
      a[16*k +: 16] = in[2*k];
      b[16*k +: 16] = in[2*k+1];
    end
    r = '0;
    case (m)
      2'd3: r = {1'b0, a} + {1'b0, b};
      2'd1: begin
        s32 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        r[31:0] = s32[31:0];
        s32 = {1'b0, a[63:32]} + {1'b0, b[63:32]};
        r[63:32] = s32[31:0];
        r[64] = s32[32];
      end
      2'd0: begin
        for (int k = 0; k < 4; k++) begin
          s16 = {1'b0, a[16*k +: 16]} + {1'b0, b[16*k +: 16]};
          r[16*k +: 16] = s16[15:0];
          r[64] = s16[16];
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [3:0][15:0] fu_q   = '0;
  logic             fu_c_q = 1'b0;
  always @(posedge clk) if (fu_on_off) {fu_c_q, fu_q} <= fu_model(fu_inputs, fu_config);
  assign fu_outputs = fu_q;
  assign fu_carry   = fu_c_q;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    req_valid  = '0;
    resp_ready = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Issue one request from requester r at a negedge and collect its response.
  task automatic run_req(input int r, input logic [1:0] m, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] ed, input logic ec,
                         input logic ee, input string tag);
    int   lat;
    logic saw_on;
    req_mode[r]  = m;
    req_a[r]     = a;
    req_b[r]     = b;
    req_valid[r] = 1'b1;
    #1;
    check({tag, "_grant"}, 128'(req_ready), 128'(4'b0001 << r));
    lat    = 0;
    saw_on = 1'b0;
    do begin
      @(negedge clk);
      req_valid[r] = 1'b0;
      lat++;
      saw_on |= fu_on_off;
    end while (resp_valid == '0 && lat < 20);
    check({tag, "_lat"},   128'(lat), 128'((m == 2'd2) ? 1 : FU_LAT + 1));
    check({tag, "_owner"}, 128'(resp_valid), 128'(4'b0001 << r));
    check({tag, "_data"},  128'(resp_data), 128'(ed));
    check({tag, "_carry"}, 128'(resp_carry), 128'(ec));
    check({tag, "_err"},   128'(resp_err), 128'(ee));
    check({tag, "_fuon"},  128'(saw_on), 128'(m != 2'd2));
    check({tag, "_fuoff"}, 128'(fu_on_off), 128'(0));
    resp_ready[r] = 1'b1;
    @(negedge clk);
    check({tag, "_drop"}, 128'(resp_valid), 128'(0));
    resp_ready[r] = 1'b0;
  endtask

  int gidx [5];
  int gt   [5];
  int ng;
  int lat;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_resp", 128'({resp_data, resp_carry, resp_err}), 128'(0));
    check("rst_fu_ctl", 128'({fu_on_off, fu_config}), 128'(0));
    check("rst_fu_inputs", 128'(fu_inputs), 128'(0));
    reset = 1'b1;
    @(negedge clk);

    // 1x64 overflow, 4x16 lane wrap, illegal mode
    run_req(0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0, "t64");
    check("t64_lanes", 128'(fu_inputs), 128'h0000_FFFF_0000_FFFF_0000_FFFF_0001_FFFF);
    check("t64_cfg_idle", 128'(fu_config), 128'(0));
    run_req(1, 2'd0, 64'h0001_FFFF_0002_8000, 64'h0001_0001_0003_8000,
            64'h0002_0000_0005_0000, 1'b0, 1'b0, "t16");
    run_req(2, 2'd2, 64'h1234, 64'h5678, 64'h0, 1'b0, 1'b1, "till");
    check("till_lanes_held", 128'(fu_inputs), 128'h0001_0001_0001_FFFF_0003_0002_8000_8000);

    // Round-robin order with everyone requesting from reset
    do_reset();
    for (int i = 0; i < 5; i++) begin gidx[i] = -1; gt[i] = -1; end
    ng = 0;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_mode[r] = 2'd3;
      req_a[r]    = 64'(r);
      req_b[r]    = 64'h10;
    end
    req_valid  = '1;
    resp_ready = '1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (ng < 5 && req_ready != '0) begin
        for (int r = 0; r < NUM_REQ; r++) if (req_ready[r]) gidx[ng] = r;
        gt[ng] = cyc;
        ng++;
      end
      @(negedge clk);
    end
    check("rr_count", 128'(ng), 128'(5));
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 128'(gidx[i]), 128'(i % 4));
    for (int i = 1; i < 5; i++) check($sformatf("rr_gap%0d", i), 128'(gt[i] - gt[i-1]), 128'(FU_LAT + 2));

    // Back-pressure on the response; non-owner resp_ready must be ignored
    do_reset();
    req_mode[3]  = 2'd1;
    req_a[3]     = 64'h0000_0001_FFFF_FFFF;
    req_b[3]     = 64'h0000_0001_0000_0001;
    req_valid[3] = 1'b1;
    #1;
    check("stall_grant", 128'(req_ready), 128'(4'b1000));
    lat = 0;
    do begin
      @(negedge clk);
      req_valid[3] = 1'b0;
      lat++;
    end while (resp_valid == '0 && lat < 20);
    check("stall_lat", 128'(lat), 128'(FU_LAT + 1));
    req_valid[0]  = 1'b1;
    resp_ready[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall_valid%0d", i), 128'(resp_valid), 128'(4'b1000));
      check($sformatf("stall_data%0d", i), 128'(resp_data), 128'h0000_0002_0000_0000);
      check($sformatf("stall_ready%0d", i), 128'(req_ready), 128'(0));
      @(negedge clk);
    end
    resp_ready = 4'b1000;
    #1;
    check("stall_release_nogrant", 128'(req_ready), 128'(0));
    @(negedge clk);
    #1;
    check("stall_release_valid", 128'(resp_valid), 128'(0));
    check("stall_next_grant", 128'(req_ready), 128'(4'b0001));
    resp_ready = '0;

    // Reset asserted mid-EXEC drops the request
    @(negedge clk);
    check("rstx_in_exec", 128'(fu_on_off), 128'(1));
    req_valid = '0;
    reset     = 1'b0;
    #1;
    check("rstx_resp_valid", 128'(resp_valid), 128'(0));
    check("rstx_resp", 128'({resp_data, resp_carry, resp_err}), 128'(0));
    check("rstx_fu_ctl", 128'({fu_on_off, fu_config}), 128'(0));
    check("rstx_fu_inputs", 128'(fu_inputs), 128'(0));
    check("rstx_req_ready", 128'(req_ready), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstx_no_resp", 128'(resp_valid), 128'(0));
    req_valid = '1;
    #1;
    check("rstx_grant0", 128'(req_ready), 128'(4'b0001));
    req_valid = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
